mont_domain_in: RTL and testbench

MONT_DOMAIN_IN -- requirements
Module: mont_domain_in

---
 rtl/mont_domain_in_if.sv | 25 ++
 rtl/mont_domain_in.sv | 91 +++++++++
 tb/tb_mont_domain_in.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mont_domain_in_if.sv
// Start/result bundle for the Montgomery-domain entry converter.
// The bench drives the master side and the converter sits on the slave side.
interface mont_domain_in_if #(
  parameter int NBITS = 2048
);
  localparam int KW = $clog2(NBITS) + 3;

  logic             enable_p;
  logic [NBITS-1:0] a;
  logic [NBITS-1:0] m;
  logic [KW-1:0]    m_size;
  logic [NBITS-1:0] y;
  logic             busy;
  logic             done_irq_p;

  modport master (
    output enable_p, a, m, m_size,
    input  y, busy, done_irq_p
  );

  modport slave (
    input  enable_p, a, m, m_size,
    output y, busy, done_irq_p
  );
endinterface

// File: rtl/mont_domain_in.sv
// Converts an operand into the Montgomery domain: y = a * 2^k mod m,
// computed as k serial modular doublings after one conditional pre-reduction.
module mont_domain_in #(
  parameter int NBITS = 2048
) (
  input  logic            clk,
  input  logic            rst,
  mont_domain_in_if.slave bus
);
  localparam int KW = $clog2(NBITS) + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [NBITS-1:0] m_r;
  logic [NBITS-1:0] u;
  logic [NBITS-1:0] y_r;
  logic [KW-1:0]    cnt;
  logic             busy_r;
  logic             done_r;

  // a < 2m, so a single conditional subtraction lands the start value below m.
  function automatic logic [NBITS-1:0] pre_reduce(
    input logic [NBITS-1:0] x,
    input logic [NBITS-1:0] md
  );
    logic [NBITS-1:0] r;
    r = x;
    if (x >= md) r = x - md;
    return r;
  endfunction

  // The extra top bit keeps the carry of 2*u so the compare against m is exact.
  function automatic logic [NBITS-1:0] mod_dbl(
    input logic [NBITS-1:0] x,
    input logic [NBITS-1:0] md
  );
    logic [NBITS:0] t;
    logic [NBITS:0] mx;
    t  = {x, 1'b0};
    mx = {1'b0, md};
    if (t >= mx) t = t - mx;
    return t[NBITS-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      m_r    <= '0;
      u      <= '0;
      cnt    <= '0;
      y_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable_p) begin
            m_r    <= bus.m;
            u      <= pre_reduce(bus.a, bus.m);
            cnt    <= bus.m_size;
            busy_r <= 1'b1;
            state  <= (bus.m_size != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          u   <= mod_dbl(u, m_r);
          cnt <= cnt - KW'(1);
          if (cnt == KW'(1)) state <= DONE;
        end
        DONE: begin
          y_r    <= u;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.y          = y_r;
  assign bus.busy       = busy_r;
  assign bus.done_irq_p = done_r;

endmodule

// File: tb/tb_mont_domain_in.sv
// Randomized and directed checks of mont_domain_in against an arithmetic
// model y = (a << k) mod m with latency k+1 edges.
module tb_mont_domain_in;
  localparam int NBITS = 8;
  localparam int KW    = $clog2(NBITS) + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  mont_domain_in_if #(.NBITS(NBITS)) bus ();

  mont_domain_in #(.NBITS(NBITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int ref_conv(input int a, input int m, input int k);
    longint v;
    v = longint'(a) << k;
    return int'(v % longint'(m));
  endfunction

  task automatic drive_start(input int a, input int m, input int k);
    bus.enable_p = 1'b1;
    bus.a        = NBITS'(a);
    bus.m        = NBITS'(m);
    bus.m_size   = KW'(k);
  endtask

  // Start at the next edge, scramble inputs afterwards, wait for done.
  task automatic run_conv(input int a, input int m, input int k,
                          output int y, output int lat, output bit seen);
    @(negedge clk);
    drive_start(a, m, k);
    @(posedge clk); #1;
    bus.enable_p = 1'b0;
    bus.a        = NBITS'($urandom);
    bus.m        = NBITS'($urandom);
    bus.m_size   = KW'($urandom);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done_irq_p) begin
        seen = 1'b1;
        break;
      end
    end
    y = int'(bus.y);
  endtask

  task automatic check_conv(input string name, input int a, input int m, input int k);
    int  y, lat, exp_y;
    bit  seen;
    exp_y = ref_conv(a, m, k);
    run_conv(a, m, k, y, lat, seen);
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: no done_irq_p within 40 edges (a=%0d m=%0d k=%0d)", name, a, m, k);
    end else begin
      n_checks++;
      if (lat !== k + 1) begin
        n_fail++;
        $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, k + 1);
      end
      n_checks++;
      if (y !== exp_y) begin
        n_fail++;
        $display("FAIL %s y: got %0d, expected %0d (a=%0d m=%0d k=%0d)", name, y, exp_y, a, m, k);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.done_irq_p !== 1'b0 || bus.busy !== 1'b0 || int'(bus.y) !== exp_y) begin
        n_fail++;
        $display("FAIL %s post-done: done=%0b busy=%0b y=%0d, expected done=0 busy=0 y=%0d",
                 name, bus.done_irq_p, bus.busy, bus.y, exp_y);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    drive_start(5, 13, 8);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.y !== '0 || bus.busy !== 1'b0 || bus.done_irq_p !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: y=%0d busy=%0b done=%0b, expected 0/0/0", bus.y, bus.busy, bus.done_irq_p);
    end
    @(negedge clk);
    bus.enable_p = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    check_conv("req026", 5, 13, 8);
    check_conv("req027", 5, 13, 0);
    check_conv("req028", 15, 13, 1);
    check_conv("req029", 254, 255, 8);
    check_conv("k_max_m3", 5, 3, 8);
  endtask

  task automatic test_ignore_and_abort();
    int  y, lat;
    bit  seen, any_done;
    // Start a long conversion, then pulse enable_p with a=1 before edge 3.
    @(negedge clk);
    drive_start(5, 13, 8);
    @(posedge clk); #1;
    bus.enable_p = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: got %0b, expected 1", bus.busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive_start(1, 13, 2);
    @(posedge clk); #1;
    bus.enable_p = 1'b0;
    lat  = 3;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done_irq_p) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen || lat !== 9 || int'(bus.y) !== 6) begin
      n_fail++;
      $display("FAIL ignore_busy: seen=%0b lat=%0d y=%0d, expected seen=1 lat=9 y=6", seen, lat, bus.y);
    end
    // New run, reset asserted for the 4th edge after the start.
    @(negedge clk);
    drive_start(5, 13, 8);
    @(posedge clk); #1;
    bus.enable_p = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.y !== '0 || bus.done_irq_p !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: busy=%0b y=%0d done=%0b, expected 0/0/0", bus.busy, bus.y, bus.done_irq_p);
    end
    @(negedge clk);
    rst = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done_irq_p || bus.busy) any_done = 1'b1;
    end
    n_checks++;
    if (any_done) begin
      n_fail++;
      $display("FAIL abort_no_done: saw done/busy after abort, expected none");
    end
    check_conv("fresh_after_rst", 5, 13, 8);
  endtask

  task automatic test_back_to_back();
    int  y, lat;
    bit  seen;
    run_conv(5, 13, 2, y, lat, seen);
    n_checks++;
    if (!seen || y !== 7) begin
      n_fail++;
      $display("FAIL b2b_first: seen=%0b y=%0d, expected seen=1 y=7", seen, y);
    end
    // Still inside the done_irq_p cycle: start again.
    drive_start(1, 13, 4);
    @(posedge clk); #1;
    bus.enable_p = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%0b, expected 1", bus.busy);
    end
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done_irq_p) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen || lat !== 5 || int'(bus.y) !== 3) begin
      n_fail++;
      $display("FAIL b2b_second: seen=%0b lat=%0d y=%0d, expected seen=1 lat=5 y=3", seen, lat, bus.y);
    end
  endtask

  task automatic test_random();
    int a, m, k, amax;
    for (int n = 0; n < 40; n++) begin
      m    = 2 * int'($urandom_range(1, 127)) + 1;
      amax = (2 * m - 1 > 255) ? 255 : 2 * m - 1;
      a    = int'($urandom_range(0, amax));
      k    = int'($urandom_range(0, NBITS));
      check_conv("random", a, m, k);
    end
  endtask

  initial begin
    bus.enable_p = 1'b0;
    bus.a        = '0;
    bus.m        = '0;
    bus.m_size   = '0;
    test_reset();
    test_directed();
    test_ignore_and_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
